kyber_bfly_issuer: RTL
======================

Name: kyber_bfly_issuer

Overview:
- Initiator-side controller for the Kyber modular arithmetic unit, which uses a start / op-select / done interface.
- Accepts one butterfly job at a time: coefficients a, b, twiddle zeta, and a mode bit.
- Issues a sequence of three arithmetic operations to the unit, holding its operands stable until done, and collects the results.
- Returns the butterfly pair (a', b') over a valid/ready handshake. Sits between the NTT/INTT address sequencer and the arithmetic unit.

Parameters:
- KYBER_Q, 3329, modulus; all data operands and results are in [0, KYBER_Q-1].
- TIMEOUT, 16, maximum cycles to wait for o_done from the arithmetic unit before flagging an error.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset, asynchronous, active-low
- i_valid  in  1  job request
- o_ready  out  1  controller can accept a job
- i_mode  in  1  0 = Cooley-Tukey (NTT), 1 = Gentleman-Sande (INTT)
- i_a  in  12  coefficient a
- i_b  in  12  coefficient b
- i_zeta  in  12  twiddle, Montgomery domain
- o_valid  out  1  result pair available
- i_ready  in  1  downstream accepts result
- o_ra  out  12  result a'
- o_rb  out  12  result b'
- o_au_a  out  12  operand A to arithmetic unit
- o_au_b  out  12  operand B to arithmetic unit
- o_au_op  out  2  op select: 2'b10 Montgomery multiply, 2'b01 add, 2'b00 subtract (A - B mod q)
- o_au_en  out  1  operation request, level, held for the whole operation
- i_au_c  in  12  arithmetic unit result
- i_au_done  in  1  arithmetic unit done pulse
- o_busy  out  1  job in progress (not IDLE)
- o_err  out  1  sticky timeout error
- o_bfly_cnt  out  16  completed butterflies (handshaked outputs), wraps at 65535 -> 0

Behaviour:
- Reset values: all outputs 0, except o_ready = 1. State is IDLE.
- Job accept: a job is accepted when i_valid && o_ready at a clock edge. i_a, i_b, i_zeta and i_mode are registered. o_ready is 1 only in IDLE.
- States: IDLE, OP1, OP2, OP3, OUT, ERR.
- CT sequence:
  - OP1: t = mont(zeta, b) = zeta*b*4096^-1 mod q.
  - OP2: a' = a + t.
  - OP3: b' = a - t.
- GS sequence:
  - OP1: a' = a + b.
  - OP2: t = a - b.
  - OP3: b' = mont(zeta, t).
- Operand hold rule: in each OPn state, o_au_en = 1, and o_au_a, o_au_b and o_au_op are driven from registers and stay constant for the whole state.
- Done detection: i_au_done is ignored in the first cycle of each OPn, to block a stale done from the previous op.
- Result capture: on the first later cycle with i_au_done = 1, i_au_c is captured into the target register (t, a' or b') and the state advances.
- Gap between ops: o_au_en drops to 0 for exactly one cycle between consecutive ops, so the unit restarts from its initial state.
- Expected latencies: add/sub done 1 cycle after issue; mont done 4 cycles after issue. The controller relies only on i_au_done, not on these counts.
- Timeout: a per-op counter resets on entry to each OPn. If it reaches TIMEOUT without a done:
  - go to ERR and set o_err = 1;
  - o_au_en = 0, o_ready = 0.
  - ERR is left only by reset.
- OUT state: o_valid = 1 and o_ra/o_rb are stable. On i_valid... no: on i_ready && o_valid, o_bfly_cnt increments and the state returns to IDLE.
- OUT back-pressure: while i_ready = 0 the controller holds in OUT indefinitely; there is no timeout in OUT.
- Zero-latency accept: if i_ready is already 1 on entry to OUT, the handshake completes in that first OUT cycle.
- No overlap: a new job is accepted no earlier than the cycle after the OUT handshake.
- Asynchronous reset mid-job: the job is dropped, o_au_en deasserts immediately, and no result is emitted.
- Range: the caller guarantees inputs < KYBER_Q. The controller does no reduction of its own; results are exactly the unit's outputs.

Test Plan:
- The bench uses a behavioural arithmetic unit model:
  - add/sub done after 1 cycle, mont done after 4 cycles;
  - mont(x, y) = x*y*4096^-1 mod 3329.
- CT, a=100, b=200, zeta=767 (767 ≡ 4096 mod q, so t = b) -> o_ra=300, o_rb=3229. The op sequence seen on o_au_op is 10, 01, 00.
- GS, a=100, b=200, zeta=767 -> o_ra=300, o_rb=3229. The op sequence is 01, 00, 10. The third op has o_au_a=767 and o_au_b=3229.
- CT wrap case, a=3000, b=1000, zeta=767 -> o_ra=671, o_rb=2000, o_bfly_cnt=1.
- Back-pressure: i_ready held 0 for 10 cycles after o_valid -> o_ra/o_rb stable, o_ready=0 and o_bfly_cnt unchanged. Raising i_ready then gives a 1-cycle handshake, and the next job is accepted the following cycle.
- Timeout: the model never asserts done in OP1 -> o_err=1 exactly TIMEOUT cycles after OP1 entry, then o_au_en=0 and o_ready=0. Reset clears o_err and sets o_ready=1.
- Stale done and reset: a done pulse in the first cycle of OP2 is ignored and the real done is captured. Asserting i_rstn=0 during OP2 gives o_au_en=0 and o_valid=0 immediately, with no result after release.

Source files
------------

// File: rtl/kyber_bfly_issuer.sv
// Kyber butterfly issuer: sequences mont/add/sub ops on the arithmetic
// unit for one CT or GS butterfly and returns (a', b') over valid/ready.
module kyber_bfly_issuer #(
  parameter int KYBER_Q = 3329,
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_mode,
  input  logic [11:0] i_a,
  input  logic [11:0] i_b,
  input  logic [11:0] i_zeta,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [11:0] o_ra,
  output logic [11:0] o_rb,
  output logic [11:0] o_au_a,
  output logic [11:0] o_au_b,
  output logic [1:0]  o_au_op,
  output logic        o_au_en,
  input  logic [11:0] i_au_c,
  input  logic        i_au_done,
  output logic        o_busy,
  output logic        o_err,
  output logic [15:0] o_bfly_cnt
);

  localparam int W  = $clog2(KYBER_Q);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP1,
    S_OP2,
    S_OP3,
    S_OUT,
    S_ERR
  } state_t;

  state_t         r_state;
  logic           r_mode;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_zeta;
  logic [W-1:0]   r_t;
  logic [W-1:0]   r_ra;
  logic [W-1:0]   r_rb;
  logic [W-1:0]   r_au_a;
  logic [W-1:0]   r_au_b;
  logic [1:0]     r_au_op;
  logic           r_au_en;
  logic           r_first;
  logic           r_gap;
  logic [TW-1:0]  r_tmo;
  logic           r_ready;
  logic           r_valid;
  logic           r_err;
  logic [15:0]    r_cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_zeta  <= '0;
      r_t     <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_au_a  <= '0;
      r_au_b  <= '0;
      r_au_op <= 2'b00;
      r_au_en <= 1'b0;
      r_first <= 1'b0;
      r_gap   <= 1'b0;
      r_tmo   <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_mode  <= i_mode;
            r_a     <= i_a;
            r_b     <= i_b;
            r_zeta  <= i_zeta;
            r_ready <= 1'b0;
            r_au_en <= 1'b1;
            r_first <= 1'b1;
            r_gap   <= 1'b0;
            r_tmo   <= '0;
            r_state <= S_OP1;
            r_au_b  <= i_b;
            if (i_mode) begin
              r_au_a  <= i_a;
              r_au_op <= OP_ADD;
            end else begin
              r_au_a  <= i_zeta;
              r_au_op <= OP_MUL;
            end
          end
        end
        S_OP1, S_OP2, S_OP3: begin
          if (r_gap) begin
            r_gap   <= 1'b0;
            r_au_en <= 1'b1;
            r_first <= 1'b1;
            r_tmo   <= '0;
          end else if (!r_first && i_au_done) begin
            // operands for the next op are loaded now so they hold
            // through the one-cycle gap and the whole next op
            r_au_en <= 1'b0;
            r_gap   <= (r_state != S_OP3);
            unique case (r_state)
              S_OP1: begin
                r_state <= S_OP2;
                r_au_a  <= r_a;
                if (r_mode) begin
                  r_ra    <= i_au_c;
                  r_au_b  <= r_b;
                  r_au_op <= OP_SUB;
                end else begin
                  r_t     <= i_au_c;
                  r_au_b  <= i_au_c;
                  r_au_op <= OP_ADD;
                end
              end
              S_OP2: begin
                r_state <= S_OP3;
                if (r_mode) begin
                  r_t     <= i_au_c;
                  r_au_a  <= r_zeta;
                  r_au_b  <= i_au_c;
                  r_au_op <= OP_MUL;
                end else begin
                  r_ra    <= i_au_c;
                  r_au_a  <= r_a;
                  r_au_b  <= r_t;
                  r_au_op <= OP_SUB;
                end
              end
              default: begin
                r_rb    <= i_au_c;
                r_valid <= 1'b1;
                r_state <= S_OUT;
              end
            endcase
          end else begin
            r_first <= 1'b0;
            if (r_tmo == TW'(TIMEOUT - 1)) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
              r_au_en <= 1'b0;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
        end
        S_OUT: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_cnt   <= r_cnt + 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_ERR: begin
          r_au_en <= 1'b0;
          r_ready <= 1'b0;
        end
        default: r_state <= S_ERR;
      endcase
    end
  end

  assign o_ready    = r_ready;
  assign o_valid    = r_valid;
  assign o_ra       = r_ra;
  assign o_rb       = r_rb;
  assign o_au_a     = r_au_a;
  assign o_au_b     = r_au_b;
  assign o_au_op    = r_au_op;
  assign o_au_en    = r_au_en;
  assign o_busy     = (r_state != S_IDLE);
  assign o_err      = r_err;
  assign o_bfly_cnt = r_cnt;

endmodule
